// File: rtl/axis_packet_sum.sv
`timescale 1ns/1ps
// axis_packet_sum
// Reduces each AXI-Stream input packet to a two-beat result packet:
// beat 0 carries the byte-masked sum, beat 1 carries {overflow, beat count}.
//
// Ports
//   axis_clk           single clock, rising edge
//   axis_reset         asynchronous active-high reset
//   S_AXIS_Sum_*       input stream (TDATA/TKEEP/TLAST/TVALID in, TREADY out)
//   M_AXIS_Sum_*       result stream (TDATA/TKEEP/TLAST/TVALID out, TREADY in)
//
// SATURATE = 1 clamps the sum at all-ones on overflow; 0 wraps modulo 2^32.
module axis_packet_sum #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        axis_clk,
    input  logic        axis_reset,
    input  logic [31:0] S_AXIS_Sum_TDATA,
    input  logic [3:0]  S_AXIS_Sum_TKEEP,
    input  logic        S_AXIS_Sum_TLAST,
    input  logic        S_AXIS_Sum_TVALID,
    output logic        S_AXIS_Sum_TREADY,
    output logic [31:0] M_AXIS_Sum_TDATA,
    output logic [3:0]  M_AXIS_Sum_TKEEP,
    output logic        M_AXIS_Sum_TLAST,
    output logic        M_AXIS_Sum_TVALID,
    input  logic        M_AXIS_Sum_TREADY
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = 4;
    localparam int unsigned CNT_W  = 31;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        OUT_SUM  = 2'd1,
        OUT_STAT = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                ovf, ovf_n;

    logic                s_ready_q, s_ready_n;
    logic                m_valid_q, m_valid_n;
    logic                m_last_q, m_last_n;
    logic [DATA_W-1:0]   m_data_q, m_data_n;

    logic [DATA_W-1:0]   masked;
    logic [DATA_W:0]     sum33;
    logic                accept;
    logic                m_xfer;

    // Zero out bytes whose keep bit is clear before they enter the sum
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(KEEP_W); i++) begin
            if (S_AXIS_Sum_TKEEP[i]) begin
                masked[8*i +: 8] = S_AXIS_Sum_TDATA[8*i +: 8];
            end
        end
    end

    assign sum33  = {1'b0, acc} + {1'b0, masked};
    assign accept = S_AXIS_Sum_TVALID & s_ready_q;
    assign m_xfer = m_valid_q & M_AXIS_Sum_TREADY;

    // State register
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    // Next state, accumulator update and next registered outputs
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        ovf_n    = ovf;
        s_ready_n = 1'b0;
        m_valid_n = 1'b0;
        m_last_n  = 1'b0;
        m_data_n  = '0;

        case (state)
            ACCUM: begin
                if (accept) begin
                    if (sum33[DATA_W]) begin
                        ovf_n = 1'b1;
                        acc_n = SATURATE ? '1 : sum33[DATA_W-1:0];
                    end else begin
                        acc_n = sum33[DATA_W-1:0];
                    end
                    // Beat count sticks at its maximum rather than wrapping
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                    if (S_AXIS_Sum_TLAST) begin
                        state_n = OUT_SUM;
                    end
                end
            end
            OUT_SUM: begin
                if (m_xfer) begin
                    state_n = OUT_STAT;
                end
            end
            OUT_STAT: begin
                if (m_xfer) begin
                    state_n = ACCUM;
                    acc_n   = '0;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            default: begin
                state_n = ACCUM;
            end
        endcase

        // Handshake outputs follow the state being entered, so they are pure flops
        case (state_n)
            ACCUM: begin
                s_ready_n = 1'b1;
            end
            OUT_SUM: begin
                m_valid_n = 1'b1;
                m_data_n  = acc_n;
            end
            OUT_STAT: begin
                m_valid_n = 1'b1;
                m_last_n  = 1'b1;
                m_data_n  = {ovf_n, cnt_n};
            end
            default: begin
                s_ready_n = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            s_ready_q <= s_ready_n;
            m_valid_q <= m_valid_n;
            m_last_q  <= m_last_n;
            m_data_q  <= m_data_n;
        end
    end

    assign S_AXIS_Sum_TREADY = s_ready_q;
    assign M_AXIS_Sum_TVALID = m_valid_q;
    assign M_AXIS_Sum_TLAST  = m_last_q;
    assign M_AXIS_Sum_TDATA  = m_data_q;
    assign M_AXIS_Sum_TKEEP  = {KEEP_W{1'b1}};

endmodule

// File: tb/tb_axis_packet_sum.sv
`timescale 1ns/1ps
// tb_axis_packet_sum
// Drives one input stream into a saturating and a wrapping instance of
// axis_packet_sum and compares their result beats against hand-computed values.
module tb_axis_packet_sum;

    logic        axis_clk;
    logic        axis_reset;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic        m_ready;

    logic        sat_s_ready, wrp_s_ready;
    logic [31:0] sat_m_data, wrp_m_data;
    logic [3:0]  sat_m_keep, wrp_m_keep;
    logic        sat_m_last, wrp_m_last;
    logic        sat_m_valid, wrp_m_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] q_sat[$];
    logic [32:0] q_wrp[$];
    time         stat_time;
    time         accept_time;

    axis_packet_sum #(.SATURATE(1'b1)) dut_sat (
        .axis_clk          (axis_clk),
        .axis_reset        (axis_reset),
        .S_AXIS_Sum_TDATA  (s_data),
        .S_AXIS_Sum_TKEEP  (s_keep),
        .S_AXIS_Sum_TLAST  (s_last),
        .S_AXIS_Sum_TVALID (s_valid),
        .S_AXIS_Sum_TREADY (sat_s_ready),
        .M_AXIS_Sum_TDATA  (sat_m_data),
        .M_AXIS_Sum_TKEEP  (sat_m_keep),
        .M_AXIS_Sum_TLAST  (sat_m_last),
        .M_AXIS_Sum_TVALID (sat_m_valid),
        .M_AXIS_Sum_TREADY (m_ready)
    );

    axis_packet_sum #(.SATURATE(1'b0)) dut_wrp (
        .axis_clk          (axis_clk),
        .axis_reset        (axis_reset),
        .S_AXIS_Sum_TDATA  (s_data),
        .S_AXIS_Sum_TKEEP  (s_keep),
        .S_AXIS_Sum_TLAST  (s_last),
        .S_AXIS_Sum_TVALID (s_valid),
        .S_AXIS_Sum_TREADY (wrp_s_ready),
        .M_AXIS_Sum_TDATA  (wrp_m_data),
        .M_AXIS_Sum_TKEEP  (wrp_m_keep),
        .M_AXIS_Sum_TLAST  (wrp_m_last),
        .M_AXIS_Sum_TVALID (wrp_m_valid),
        .M_AXIS_Sum_TREADY (m_ready)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // Capture transferred result beats midway between rising edges
    always @(negedge axis_clk) begin
        if (!axis_reset) begin
            if (sat_m_valid && m_ready) begin
                q_sat.push_back({sat_m_last, sat_m_data});
                if (sat_m_last) stat_time = $time;
            end
            if (wrp_m_valid && m_ready) begin
                q_wrp.push_back({wrp_m_last, wrp_m_data});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns just after the accepting edge
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        while (!sat_s_ready && n < 100) begin
            @(posedge axis_clk); #1;
            n++;
        end
        if (n >= 100) begin
            check("send_timeout", 32'(sat_s_ready), 32'd1);
        end else begin
            @(posedge axis_clk); #1;
            accept_time = $time;
        end
        s_valid = 1'b0;
    endtask

    // Wait for a two-beat result from both instances and compare it
    task automatic expect_pkt(input string tag, input logic [31:0] sum_sat,
                              input logic [31:0] sum_wrp, input logic [31:0] stat);
        int n = 0;
        logic [32:0] b0, b1;
        while ((q_sat.size() < 2 || q_wrp.size() < 2) && n < 200) begin
            @(posedge axis_clk); #1;
            n++;
        end
        if (n >= 200) begin
            check({tag, "_timeout"}, 32'(q_sat.size()), 32'd2);
            q_sat.delete();
            q_wrp.delete();
            return;
        end
        b0 = q_sat.pop_front();
        b1 = q_sat.pop_front();
        check({tag, "_sat_sum"},       b0[31:0],       sum_sat);
        check({tag, "_sat_sum_last"},  32'(b0[32]),    32'd0);
        check({tag, "_sat_stat"},      b1[31:0],       stat);
        check({tag, "_sat_stat_last"}, 32'(b1[32]),    32'd1);
        b0 = q_wrp.pop_front();
        b1 = q_wrp.pop_front();
        check({tag, "_wrp_sum"},       b0[31:0],       sum_wrp);
        check({tag, "_wrp_stat"},      b1[31:0],       stat);
    endtask

    initial begin
        axis_reset = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        stat_time   = 0;
        accept_time = 0;

        // Reset values while reset is held
        #1 axis_reset = 1'b1;
        #2;
        check("rst_s_ready", 32'(sat_s_ready), 32'd0);
        check("rst_m_valid", 32'(sat_m_valid), 32'd0);
        check("rst_m_data",  sat_m_data,       32'h0);
        check("rst_m_last",  32'(sat_m_last),  32'd0);
        check("rst_m_keep",  32'(sat_m_keep),  32'hF);
        repeat (2) @(posedge axis_clk);
        #1 axis_reset = 1'b0;
        check("rst_rdy_before_edge", 32'(sat_s_ready), 32'd0);
        @(posedge axis_clk); #1;
        check("rst_rdy_after_edge",  32'(sat_s_ready), 32'd1);

        // {1,2,3,4}
        send(32'd1, 4'hF, 1'b0);
        send(32'd2, 4'hF, 1'b0);
        send(32'd3, 4'hF, 1'b0);
        send(32'd4, 4'hF, 1'b1);
        expect_pkt("p1234", 32'h0000_000A, 32'h0000_000A, 32'h0000_0004);

        // Single masked beat
        send(32'h1234_5678, 4'b0011, 1'b1);
        expect_pkt("single", 32'h0000_5678, 32'h0000_5678, 32'h0000_0001);

        // Overflow: clamp vs wrap, sticky flag in status
        send(32'hFFFF_FFF0, 4'hF, 1'b0);
        send(32'h0000_0020, 4'hF, 1'b0);
        send(32'h0000_0001, 4'hF, 1'b1);
        expect_pkt("ovf", 32'hFFFF_FFFF, 32'h0000_0011, 32'h8000_0003);

        // Backpressure: result held stable, input pulses ignored
        m_ready = 1'b0;
        send(32'd5, 4'hF, 1'b0);
        send(32'd6, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("bp_m_valid", 32'(sat_m_valid), 32'd1);
            check("bp_m_data",  sat_m_data,       32'h0000_000B);
            check("bp_m_last",  32'(sat_m_last),  32'd0);
            check("bp_s_ready", 32'(sat_s_ready), 32'd0);
            s_data  = 32'h0000_00FF;
            s_keep  = 4'hF;
            s_last  = 1'b1;
            s_valid = 1'b1;
            @(posedge axis_clk); #1;
            s_valid = 1'b0;
        end
        m_ready = 1'b1;
        expect_pkt("bp", 32'h0000_000B, 32'h0000_000B, 32'h0000_0002);

        // Reset mid-packet discards the partial sum
        send(32'd1, 4'hF, 1'b0);
        send(32'd2, 4'hF, 1'b0);
        axis_reset = 1'b1;
        #2;
        check("midpkt_rst_s_ready", 32'(sat_s_ready), 32'd0);
        @(posedge axis_clk); #1;
        axis_reset = 1'b0;
        send(32'd7, 4'hF, 1'b1);
        expect_pkt("after_rst", 32'h0000_0007, 32'h0000_0007, 32'h0000_0001);
        repeat (4) @(posedge axis_clk);
        #1;
        check("after_rst_no_extra", 32'(q_sat.size()), 32'd0);

        // Reset mid-output discards the pending result
        m_ready = 1'b0;
        send(32'd9, 4'hF, 1'b1);
        check("midout_valid", 32'(sat_m_valid), 32'd1);
        axis_reset = 1'b1;
        #2;
        check("midout_rst_valid", 32'(sat_m_valid), 32'd0);
        check("midout_rst_data",  sat_m_data,       32'h0);
        @(posedge axis_clk); #1;
        axis_reset = 1'b0;
        m_ready = 1'b1;
        repeat (5) @(posedge axis_clk);
        #1;
        check("midout_no_emit", 32'(q_sat.size()), 32'd0);

        // Back-to-back single-beat packets: second waits for first status transfer
        send(32'd1, 4'hF, 1'b1);
        send(32'd2, 4'hF, 1'b1);
        check("b2b_gap", 32'(accept_time - stat_time), 32'd16);
        expect_pkt("b2b_a", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001);
        expect_pkt("b2b_b", 32'h0000_0002, 32'h0000_0002, 32'h0000_0001);

        // Sparse keep and an all-null beat that still counts
        send(32'h1122_3344, 4'b1010, 1'b0);
        send(32'hAABB_CCDD, 4'b0000, 1'b1);
        expect_pkt("keep_mix", 32'h1100_3300, 32'h1100_3300, 32'h0000_0002);

        // Lone all-null beat carrying TLAST
        send(32'hFFFF_FFFF, 4'b0000, 1'b1);
        expect_pkt("keep_null", 32'h0000_0000, 32'h0000_0000, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
